// File: rtl/motor_ramp.sv
// rtl/motor_ramp.sv - slew-limited speed-to-duty ramp with reversal dwell, feeding the pwm_dir stage
module motor_ramp #(
  parameter int CLK_FREQUENCY       = 60_000_000,
  parameter int STEP_FREQUENCY      = 1_000,
  parameter int REVERSE_DWELL_TICKS = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [7:0] i_target_speed,
  input  logic [3:0] i_ramp_step,
  input  logic       i_coast_req,
  output logic [6:0] o_duty_cycle,
  output logic       o_dir_out,
  output logic       o_float,
  output logic       o_ramping,
  output logic       o_at_target
);

  localparam int TICK_COUNT = CLK_FREQUENCY / STEP_FREQUENCY;
  localparam int TW         = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int DW_RAW     = $clog2(REVERSE_DWELL_TICKS + 1);
  localparam int DW         = (DW_RAW < 2) ? 2 : DW_RAW;

  typedef enum logic [1:0] {IDLE, RUN, DWELL} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [TW-1:0]   r_tick_cnt;
  logic [DW-1:0]   r_dwell_cnt;
  logic [DW-1:0]   w_dwell_next;
  logic [6:0]      r_duty;
  logic            r_dir;
  logic            r_float;
  logic            r_ramping;
  logic            r_at_target;

  logic [7:0]      w_abs;
  logic [7:0]      w_mag;
  logic            w_tgt_dir;
  logic [7:0]      w_step;
  logic [7:0]      w_duty8;
  logic [7:0]      w_eff_mag;
  logic [7:0]      w_up_sum;
  logic [7:0]      w_dn_lim;
  logic [7:0]      w_duty_next;
  logic            w_dir_next;
  logic            w_tick;
  logic            w_dwell_last;
  logic            w_stop;
  logic            w_at_cond;

  // Target decode: -128 becomes 128 in the unsigned 8-bit magnitude, then clamps to 100.
  // A zero magnitude never requests a reversal.
  always_comb begin
    w_abs     = i_target_speed[7] ? (~i_target_speed + 8'd1) : i_target_speed;
    w_mag     = (w_abs > 8'd100) ? 8'd100 : w_abs;
    w_tgt_dir = (w_mag == 8'd0) ? r_dir : i_target_speed[7];
    w_step    = (i_ramp_step == 4'd0) ? 8'd100 : {4'd0, i_ramp_step};
    w_duty8   = {1'b0, r_duty};
    w_eff_mag = (r_state == IDLE) ? 8'd0 : w_mag;
    w_up_sum  = w_duty8 + w_step;
    w_dn_lim  = w_mag + w_step;
    w_tick    = (r_state != IDLE) && (r_tick_cnt == TW'(TICK_COUNT - 1));
    // The tick that enters DWELL counts as the first dwell tick, so the flip lands
    // REVERSE_DWELL_TICKS-1 ticks later (minimum one tick).
    w_dwell_last = (r_dwell_cnt <= DW'(2));
    w_stop    = !i_en || i_coast_req;
    w_at_cond = (r_state != DWELL) && (w_duty8 == w_eff_mag) &&
                ((r_dir == w_tgt_dir) || (w_eff_mag == 8'd0));
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic; stop requests win over everything, a returning target aborts the dwell
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_stop) w_state_next = RUN;
      RUN: begin
        if (w_stop)                                                  w_state_next = IDLE;
        else if (w_tick && (w_tgt_dir != r_dir) && (r_duty == 7'd0)) w_state_next = DWELL;
      end
      DWELL: begin
        if (w_stop)                       w_state_next = IDLE;
        else if (w_tgt_dir == r_dir)      w_state_next = RUN;
        else if (w_tick && w_dwell_last)  w_state_next = RUN;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic: next duty, direction and dwell count, all saturating in 8 bits
  always_comb begin
    w_duty_next  = w_duty8;
    w_dir_next   = r_dir;
    w_dwell_next = r_dwell_cnt;
    case (r_state)
      RUN: begin
        if (w_tick) begin
          if (w_tgt_dir != r_dir) begin
            if (r_duty == 7'd0) w_dwell_next = DW'(REVERSE_DWELL_TICKS);
            else                w_duty_next  = (w_duty8 > w_step) ? (w_duty8 - w_step) : 8'd0;
          end else if (w_duty8 < w_mag) begin
            w_duty_next = (w_up_sum > w_mag) ? w_mag : w_up_sum;
          end else if (w_duty8 > w_mag) begin
            w_duty_next = (w_duty8 > w_dn_lim) ? (w_duty8 - w_step) : w_mag;
          end
        end
      end
      DWELL: begin
        w_duty_next = 8'd0;
        if ((w_state_next == RUN) && (w_tgt_dir != r_dir)) w_dir_next = ~r_dir;
        else if ((w_state_next == DWELL) && w_tick)        w_dwell_next = r_dwell_cnt - DW'(1);
      end
      default: w_duty_next = 8'd0;
    endcase
    if (w_state_next == IDLE) w_duty_next = 8'd0;
  end

  // Tick counter: free-runs outside IDLE, held at 0 while idle or about to idle
  always_ff @(posedge i_clk) begin
    if (i_reset || (r_state == IDLE) || (w_state_next == IDLE)) r_tick_cnt <= '0;
    else if (w_tick)                                            r_tick_cnt <= '0;
    else                                                        r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // Registered outputs and dwell counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_duty      <= 7'd0;
      r_dir       <= 1'b0;
      r_float     <= 1'b0;
      r_ramping   <= 1'b0;
      r_at_target <= 1'b1;
      r_dwell_cnt <= '0;
    end else begin
      r_duty      <= w_duty_next[6:0];
      r_dir       <= w_dir_next;
      r_float     <= i_coast_req;
      r_ramping   <= (r_state != IDLE) && !w_at_cond;
      r_at_target <= w_at_cond;
      r_dwell_cnt <= w_dwell_next;
    end
  end

  assign o_duty_cycle = r_duty;
  assign o_dir_out    = r_dir;
  assign o_float      = r_float;
  assign o_ramping    = r_ramping;
  assign o_at_target  = r_at_target;

endmodule
